// File: rtl/mem_arb_2h.sv
// ---------------------------------------------------------------------------
// mem_arb_2h
//
// Two-host arbiter in front of a single-port memory with a fixed 1-cycle
// response latency. Host 0 is the core's instruction-fetch port, host 1 is
// the core's data port. At most one transaction is outstanding. Each
// response is steered back to the host that issued it. A new grant may be
// issued in the same cycle that the previous response retires, which gives
// one grant per cycle when requests are sustained.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   : alternate between hosts on a collision
//                       undefined : fixed priority, host 1 wins collisions
//
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   hX_req_i / hX_we_i / hX_be_i   host request, write enable, byte enables
//   hX_addr_i / hX_wdata_i         host byte address, write data
//   hX_gnt_o                       request accepted this cycle (combinational)
//   hX_rvalid_o / hX_rdata_o       response for host X, read data
//   dev_req_o .. dev_wdata_o       muxed memory request
//   dev_rvalid_i / dev_rdata_i     memory response
//   err_o                          sticky protocol error (spurious response)
// ---------------------------------------------------------------------------
module mem_arb_2h #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            h0_req_i,
    input  logic            h0_we_i,
    input  logic [DW/8-1:0] h0_be_i,
    input  logic [AW-1:0]   h0_addr_i,
    input  logic [DW-1:0]   h0_wdata_i,
    output logic            h0_gnt_o,
    output logic            h0_rvalid_o,
    output logic [DW-1:0]   h0_rdata_o,

    input  logic            h1_req_i,
    input  logic            h1_we_i,
    input  logic [DW/8-1:0] h1_be_i,
    input  logic [AW-1:0]   h1_addr_i,
    input  logic [DW-1:0]   h1_wdata_i,
    output logic            h1_gnt_o,
    output logic            h1_rvalid_o,
    output logic [DW-1:0]   h1_rdata_o,

    output logic            dev_req_o,
    output logic            dev_we_o,
    output logic [DW/8-1:0] dev_be_o,
    output logic [AW-1:0]   dev_addr_o,
    output logic [DW-1:0]   dev_wdata_o,
    input  logic            dev_rvalid_i,
    input  logic [DW-1:0]   dev_rdata_i,

    output logic            err_o
);

    localparam int BW = DW / 8;

    // Request fields of one host, bundled so the winner can be muxed as a unit.
    typedef struct packed {
        logic          we;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } hreq_t;

    hreq_t [1:0] hreq;
    logic  [1:0] req;

    assign hreq[0] = '{we: h0_we_i, be: h0_be_i, addr: h0_addr_i, wdata: h0_wdata_i};
    assign hreq[1] = '{we: h1_we_i, be: h1_be_i, addr: h1_addr_i, wdata: h1_wdata_i};
    assign req     = {h1_req_i, h0_req_i};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic out_q,  out_d;    // a transaction is outstanding
    logic own_q,  own_d;    // host that owns the outstanding transaction
    logic last_q, last_d;   // host granted most recently
    logic err_q,  err_d;    // sticky: response seen with nothing outstanding

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic        can_issue;
    logic        both;
    logic        win;       // winning host index, meaningful when issue=1
    logic        issue;
    logic [1:0]  gnt;
    hreq_t       dev_fields;
    logic        resp;

    always_comb begin
        // A response retiring this cycle frees the slot for a same-cycle grant.
        can_issue = !out_q || dev_rvalid_i;
        both      = &req;

`ifdef ARB_ROUND_ROBIN_EN
        // On a collision give it to whoever did not win last time.
        win = both ? !last_q : req[1];
`else
        // On a collision the data port (host 1) always wins.
        win = req[1];
`endif

        issue = can_issue && (|req);

        gnt = 2'b00;
        if (issue) begin
            gnt[win] = 1'b1;
        end

        // Gate the muxed fields so the memory sees zeros when idle.
        dev_fields = '0;
        if (issue) begin
            dev_fields = hreq[win];
        end

        // Only a response that matches an outstanding transaction is routed.
        resp = dev_rvalid_i && out_q;
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        out_d  = out_q;
        own_d  = own_q;
        last_d = last_q;
        err_d  = err_q;

        if (issue) begin
            // A same-cycle retire and grant keeps the slot occupied.
            out_d  = 1'b1;
            own_d  = win;
            last_d = win;
        end else if (dev_rvalid_i) begin
            out_d  = 1'b0;
        end

        if (dev_rvalid_i && !out_q) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q  <= 1'b0;
            own_q  <= 1'b0;
            last_q <= 1'b1;   // so host 0 wins the first round-robin collision
            err_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            own_q  <= own_d;
            last_q <= last_d;
            err_q  <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign h0_gnt_o    = gnt[0];
    assign h1_gnt_o    = gnt[1];

    assign dev_req_o   = issue;
    assign dev_we_o    = dev_fields.we;
    assign dev_be_o    = dev_fields.be;
    assign dev_addr_o  = dev_fields.addr;
    assign dev_wdata_o = dev_fields.wdata;

    assign h0_rvalid_o = resp && !own_q;
    assign h1_rvalid_o = resp &&  own_q;

    // Read data is shared; rvalid tells each host whether it is theirs.
    assign h0_rdata_o  = dev_rdata_i;
    assign h1_rdata_o  = dev_rdata_i;

    assign err_o       = err_q;

endmodule

// File: tb/tb_mem_arb_2h.sv
module tb_mem_arb_2h;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            h0_req, h0_we, h1_req, h1_we;
    logic [3:0]      h0_be, h1_be;
    logic [31:0]     h0_addr, h1_addr, h0_wdata, h1_wdata;
    logic            h0_gnt, h1_gnt, h0_rvalid, h1_rvalid;
    logic [31:0]     h0_rdata, h1_rdata;
    logic            dev_req, dev_we;
    logic [3:0]      dev_be;
    logic [31:0]     dev_addr, dev_wdata;
    logic            dev_rvalid;
    logic [31:0]     dev_rdata;
    logic            err;

    // memory model + spurious-response injection
    logic [31:0]     mem [0:63];
    logic            mem_rvalid_q;
    logic [31:0]     mem_rdata_q;
    logic            force_rv;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign dev_rvalid = mem_rvalid_q | force_rv;
    assign dev_rdata  = mem_rdata_q;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    end

    // 1-cycle memory, held in reset together with the arbiter
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_rvalid_q <= 1'b0;
            mem_rdata_q  <= 32'h0;
        end else begin
            mem_rvalid_q <= dev_req;
            if (dev_req) begin
                if (dev_we) begin
                    for (int b = 0; b < 4; b++)
                        if (dev_be[b]) mem[dev_addr[7:2]][b*8 +: 8] <= dev_wdata[b*8 +: 8];
                    mem_rdata_q <= 32'h0;
                end else begin
                    mem_rdata_q <= mem[dev_addr[7:2]];
                end
            end
        end
    end

    mem_arb_2h #(.AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .h0_req_i(h0_req), .h0_we_i(h0_we), .h0_be_i(h0_be), .h0_addr_i(h0_addr),
        .h0_wdata_i(h0_wdata), .h0_gnt_o(h0_gnt), .h0_rvalid_o(h0_rvalid), .h0_rdata_o(h0_rdata),
        .h1_req_i(h1_req), .h1_we_i(h1_we), .h1_be_i(h1_be), .h1_addr_i(h1_addr),
        .h1_wdata_i(h1_wdata), .h1_gnt_o(h1_gnt), .h1_rvalid_o(h1_rvalid), .h1_rdata_o(h1_rdata),
        .dev_req_o(dev_req), .dev_we_o(dev_we), .dev_be_o(dev_be), .dev_addr_o(dev_addr),
        .dev_wdata_o(dev_wdata), .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata),
        .err_o(err)
    );

    task automatic idle_inputs();
        h0_req = 0; h0_we = 0; h0_be = 4'h0; h0_addr = 32'h0; h0_wdata = 32'h0;
        h1_req = 0; h1_we = 0; h1_be = 4'h0; h1_addr = 32'h0; h1_wdata = 32'h0;
        force_rv = 0;
    endtask

    // Drive at negedge, then settle before checking the combinational outputs.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 0;
        #12;
        n_vec++;
        if ({h0_gnt, h1_gnt, h0_rvalid, h1_rvalid, dev_req, err} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_state: got %b expected 000000",
                     {h0_gnt, h1_gnt, h0_rvalid, h1_rvalid, dev_req, err});
        end
        step(); rst_ni = 1;
        for (int c = 0; c < 5; c++) begin
            step(); #1;
            n_vec++;
            if ({h0_gnt, h1_gnt, h0_rvalid, h1_rvalid, dev_req, err} !== 6'b0) begin
                n_err++;
                $display("FAIL idle_cycle%0d: got %b expected 000000", c,
                         {h0_gnt, h1_gnt, h0_rvalid, h1_rvalid, dev_req, err});
            end
        end
    endtask

    task automatic test_h0_read();
        step();
        h0_req = 1; h0_we = 0; h0_be = 4'hF; h0_addr = 32'h10;
        #1;
        n_vec++;
        if ({h0_gnt, h1_gnt, dev_req} !== 3'b101 || dev_addr !== 32'h10 || dev_we !== 1'b0) begin
            n_err++;
            $display("FAIL h0_read_grant: gnt0/gnt1/req=%b addr=%h we=%b expected 101 00000010 0",
                     {h0_gnt, h1_gnt, dev_req}, dev_addr, dev_we);
        end
        step(); idle_inputs(); #1;
        n_vec++;
        if (h0_rvalid !== 1'b1 || h1_rvalid !== 1'b0 || h0_rdata !== 32'hA000_0004) begin
            n_err++;
            $display("FAIL h0_read_resp: rv0=%b rv1=%b rdata=%h expected 1 0 a0000004",
                     h0_rvalid, h1_rvalid, h0_rdata);
        end
        step(); #1;
        n_vec++;
        if ({h0_rvalid, h1_rvalid, dev_req} !== 3'b000) begin
            n_err++;
            $display("FAIL h0_read_after: rv/req=%b expected 000", {h0_rvalid, h1_rvalid, dev_req});
        end
    endtask

    task automatic test_back_to_back();
        step();
        h1_req = 1; h1_we = 1; h1_be = 4'hF; h1_addr = 32'h20; h1_wdata = 32'hDEAD_BEEF;
        #1;
        n_vec++;
        if ({h0_gnt, h1_gnt} !== 2'b01 || dev_we !== 1'b1 || dev_wdata !== 32'hDEAD_BEEF
            || dev_addr !== 32'h20 || dev_be !== 4'hF) begin
            n_err++;
            $display("FAIL h1_write_grant: gnt=%b we=%b wdata=%h addr=%h be=%h expected 01 1 deadbeef 00000020 f",
                     {h0_gnt, h1_gnt}, dev_we, dev_wdata, dev_addr, dev_be);
        end
        // read follows immediately: write response and read grant share a cycle
        step();
        h1_we = 0; h1_wdata = 32'h0;
        #1;
        n_vec++;
        if (h1_rvalid !== 1'b1 || h0_rvalid !== 1'b0 || h1_gnt !== 1'b1 || dev_req !== 1'b1) begin
            n_err++;
            $display("FAIL h1_write_resp_and_read_grant: rv1=%b rv0=%b gnt1=%b req=%b expected 1 0 1 1",
                     h1_rvalid, h0_rvalid, h1_gnt, dev_req);
        end
        step(); idle_inputs(); #1;
        n_vec++;
        if (h1_rvalid !== 1'b1 || h0_rvalid !== 1'b0 || h1_rdata !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL h1_read_resp: rv1=%b rv0=%b rdata=%h expected 1 0 deadbeef",
                     h1_rvalid, h0_rvalid, h1_rdata);
        end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_gnt;
        logic [1:0]  prev_gnt;
        logic [31:0] exp_rd;
        // fresh reset so last_q starts at 1
        step(); idle_inputs(); rst_ni = 0;
        step(); rst_ni = 1;
        step();
        h0_req = 1; h0_addr = 32'h0; h0_be = 4'hF;
        h1_req = 1; h1_addr = 32'h4; h1_be = 4'hF;
        prev_gnt = 2'b00;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            #1;
`ifdef ARB_ROUND_ROBIN_EN
            exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;   // {h1,h0}
`else
            exp_gnt = 2'b10;
`endif
            n_vec++;
            if ({h1_gnt, h0_gnt} !== exp_gnt || dev_req !== 1'b1) begin
                n_err++;
                $display("FAIL contention_gnt%0d: gnt{h1,h0}=%b req=%b expected %b 1",
                         k, {h1_gnt, h0_gnt}, dev_req, exp_gnt);
            end
            if (k > 0) begin
                exp_rd = prev_gnt[1] ? 32'hA000_0001 : 32'hA000_0000;
                n_vec++;
                if ({h1_rvalid, h0_rvalid} !== prev_gnt || dev_rdata !== exp_rd) begin
                    n_err++;
                    $display("FAIL contention_rv%0d: rv{h1,h0}=%b rdata=%h expected %b %h",
                             k, {h1_rvalid, h0_rvalid}, dev_rdata, prev_gnt, exp_rd);
                end
            end
            prev_gnt = exp_gnt;
        end
        step(); idle_inputs(); #1;
        n_vec++;
        if ({h1_rvalid, h0_rvalid} !== prev_gnt || dev_req !== 1'b0) begin
            n_err++;
            $display("FAIL contention_last_rv: rv{h1,h0}=%b req=%b expected %b 0",
                     {h1_rvalid, h0_rvalid}, dev_req, prev_gnt);
        end
    endtask

    task automatic test_spurious();
        step(); idle_inputs(); force_rv = 1; #1;
        n_vec++;
        if ({h0_rvalid, h1_rvalid, err} !== 3'b000) begin
            n_err++;
            $display("FAIL spurious_no_rv: rv0/rv1/err=%b expected 000", {h0_rvalid, h1_rvalid, err});
        end
        step(); force_rv = 0; #1;
        n_vec++;
        if (err !== 1'b1) begin
            n_err++;
            $display("FAIL spurious_err_set: err=%b expected 1", err);
        end
        step(); step(); #1;
        n_vec++;
        if (err !== 1'b1) begin
            n_err++;
            $display("FAIL spurious_err_held: err=%b expected 1", err);
        end
        #1 rst_ni = 0; #1;
        n_vec++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL spurious_err_reset: err=%b expected 0", err);
        end
        step(); rst_ni = 1;
    endtask

    task automatic test_reset_mid_txn();
        step();
        h0_req = 1; h0_addr = 32'h8; h0_be = 4'hF; #1;
        n_vec++;
        if (h0_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_grant: gnt0=%b expected 1", h0_gnt);
        end
        step(); idle_inputs(); rst_ni = 0; #1;
        n_vec++;
        if ({h0_rvalid, h1_rvalid} !== 2'b00) begin
            n_err++;
            $display("FAIL midrst_in_reset: rv=%b expected 00", {h0_rvalid, h1_rvalid});
        end
        step(); rst_ni = 1;
        for (int c = 0; c < 3; c++) begin
            step(); #1;
            n_vec++;
            if ({h0_rvalid, h1_rvalid, err} !== 3'b000) begin
                n_err++;
                $display("FAIL midrst_after%0d: rv0/rv1/err=%b expected 000", c,
                         {h0_rvalid, h1_rvalid, err});
            end
        end
    endtask

    initial begin
        rst_ni = 0;
        idle_inputs();
        test_reset();
        test_h0_read();
        test_back_to_back();
        test_contention();
        test_spurious();
        test_reset_mid_txn();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arb_2h.md
# mem_arb_2h

Two-host arbiter sharing the single-port, 1-cycle-latency 32-bit memory between the core's instruction-fetch port (host 0) and data port (host 1). Sits between the two core-side request/grant/rvalid interfaces and the memory's req/we/be/addr/wdata/rvalid/rdata port. Allows at most one outstanding transaction. Routes each response back to the host that issued it, and supports back-to-back grants at full throughput.

## Interface
Parameters:
- AW, 32, address width passed through to the memory
- DW, 32, data width; byte enables are DW/8 bits

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- h0_req_i / h1_req_i  in  1  host request; held until granted
- h0_we_i / h1_we_i  in  1  write enable
- h0_be_i / h1_be_i  in  DW/8  byte enables
- h0_addr_i / h1_addr_i  in  AW  byte address
- h0_wdata_i / h1_wdata_i  in  DW  write data
- h0_gnt_o / h1_gnt_o  out  1  grant; request accepted this cycle
- h0_rvalid_o / h1_rvalid_o  out  1  response valid for this host
- h0_rdata_o / h1_rdata_o  out  DW  read data; both driven from dev_rdata_i
- dev_req_o  out  1  memory request
- dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o  out  1/DW/8/AW/DW  muxed request fields
- dev_rvalid_i  in  1  memory response valid, one cycle after dev_req_o
- dev_rdata_i  in  DW  memory read data
- err_o  out  1  sticky protocol error

## Operation
- Registered state:
  - out_q: transaction outstanding
  - own_q: owner of the outstanding transaction (0/1)
  - last_q: last granted host
  - err_q: sticky protocol error
- Reset values: out_q=0, own_q=0, last_q=1, err_q=0. All outputs are combinational from state and inputs. With no requests and no dev_rvalid_i, every output is 0 (rdata outputs follow dev_rdata_i).
- can_issue = !out_q || dev_rvalid_i. The response retiring this cycle frees the slot in the same cycle.
- Arbitration when can_issue is high:
  - Only one host requesting: that host wins.
  - Both requesting: the arbitration mode (see Configuration) picks the winner.
- Winner handling:
  - hX_gnt_o=1 and dev_req_o=1.
  - dev_we/be/addr/wdata are muxed from the winner.
  - Next cycle: out_q=1, own_q=winner, last_q=winner.
- When can_issue is low: no grant and dev_req_o=0. Requests stay pending.
- Response:
  - h{own_q}_rvalid_o = dev_rvalid_i && out_q.
  - Writes also receive rvalid.
  - out_q clears on dev_rvalid_i unless a new grant occurs in the same cycle.
- Spurious response (dev_rvalid_i while out_q=0): no host rvalid is raised, and err_q is set. err_q clears only on reset.
- The loser's request fields are ignored. Its grant stays 0 until it wins.

## Timing
- Grant is zero-cycle: combinational from req in the cycle of acceptance.
- Response latency: hX_rvalid_o is asserted exactly 1 cycle after hX_gnt_o, given the 1-cycle memory.
- Throughput: one grant per cycle sustained, because grant and retire can occur in the same cycle.
- Reset mid-transaction clears out_q, and any late dev_rvalid_i after reset release sets err_o. The bench must hold the memory in reset with the arbiter.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the host != last_q. Each of two continuously requesting hosts is granted every other cycle.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, and host 1 (data) always wins simultaneous requests. last_q is still maintained but unused.

## Test plan
- Reset, then no requests for 5 cycles -> all gnt/rvalid/dev_req_o/err_o = 0.
- h0 read addr 0x10 alone -> h0_gnt_o=1 in cycle 0, dev_addr_o=0x10. In cycle 1, h0_rvalid_o=1 and h0_rdata_o = mem word 4; h1_rvalid_o=0.
- h1 write 0xDEADBEEF, be=0xF, addr 0x20, then h1 read 0x20 -> write gets h1_rvalid_o the next cycle. Read returns 0xDEADBEEF one cycle after its grant.
- h0 and h1 both request continuously for 6 cycles, round-robin build:
  - Grants alternate h0,h1,h0,h1,h0,h1 (last_q=1 after reset).
  - Each rvalid reaches the matching host the next cycle.
  - Fixed-priority build: h1 granted all 6 cycles and h0 is never granted.
- Force dev_rvalid_i=1 with no outstanding transaction -> no host rvalid, err_o=1 and held. Assert rst_ni=0 -> err_o=0 immediately.
- Assert rst_ni=0 one cycle after a grant -> out_q cleared, no rvalid delivered to any host after release.
